// File: rtl/vga_pkg.sv
// Shared constants for the pixel-buffer DMA page-flip controller:
// slave register map, status bit position and the flip FSM states.
package vga_pkg;

   localparam logic [1:0] REG_FRONT  = 2'd0;
   localparam logic [1:0] REG_BACK   = 2'd1;
   localparam logic [1:0] REG_RES    = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int STATUS_SWAP_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_BACK,
      ST_WR_TRIG,
      ST_GAP,
      ST_RD,
      ST_WAIT,
      ST_DONE
   } swap_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vga_swap_pending.sv
// One-deep request slot: the newest request wins, and overwriting a
// still-valid entry raises a sticky overrun flag until explicitly cleared.
module vga_swap_pending (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_push,
   input  logic [31:0] i_addr,
   input  logic        i_pop,
   input  logic        i_clr_ovr,
   output logic        o_vld,
   output logic        o_vld_nxt,
   output logic [31:0] o_addr,
   output logic        o_overrun
);

   logic        r_vld;
   logic [31:0] r_addr;
   logic        r_ovr;

   assign o_vld     = r_vld;
   assign o_addr    = r_addr;
   assign o_overrun = r_ovr;
   // Lets the parent register a busy flag without an extra cycle of lag.
   assign o_vld_nxt = i_push | (r_vld & ~i_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld  <= 1'b0;
         r_addr <= '0;
         r_ovr  <= 1'b0;
      end else begin
         if (i_push) begin
            r_vld  <= 1'b1;
            r_addr <= i_addr;
         end else if (i_pop) begin
            r_vld  <= 1'b0;
         end
         if (i_push && r_vld && !i_pop)
            r_ovr <= 1'b1;
         else if (i_clr_ovr)
            r_ovr <= 1'b0;
      end
   end

endmodule

// File: rtl/vga_frame_swap_ctrl.sv
// Page-flip sequencer: writes the back-buffer address, triggers the swap,
// polls status until vsync completes it, then reports done or timeout.
module vga_frame_swap_ctrl
   import vga_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int POLL_GAP     = 16,
   parameter int TIMEOUT      = 2000000,
   parameter int CNT_W        = 16
) (
   input  logic             sys_clk_clk,
   input  logic             sys_reset_reset_n,
   input  logic             swap_req,
   input  logic [31:0]      swap_addr,
   output logic             swap_busy,
   output logic             swap_done,
   output logic             swap_timeout,
   output logic             swap_overrun,
   output logic [CNT_W-1:0] frame_count,
   output logic [1:0]       avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [3:0]       avm_byteenable,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata
);

   localparam int DW = $clog2(max2(READ_LATENCY, POLL_GAP)) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   swap_state_e      r_state, w_next;
   logic [DW-1:0]    r_cnt;
   logic [TW-1:0]    r_to;
   logic             w_to_exp, w_to_evt, w_start;
   logic [31:0]      w_req_addr, w_sel_addr, w_pend_addr;
   logic             w_pend_vld, w_pend_vld_nxt, w_push, w_clr_ovr;
   logic             r_wr, r_rd, r_done, r_busy, r_tout;
   logic [1:0]       r_addr;
   logic [3:0]       r_be;
   logic [31:0]      r_wdata;
   logic [CNT_W-1:0] r_fc;
   logic             w_unused_rd;

   assign w_unused_rd = &{1'b0, avm_readdata};
   assign w_req_addr  = {swap_addr[31:2], 2'b00};
   assign w_sel_addr  = swap_req ? w_req_addr : w_pend_addr;
   assign w_push      = swap_req && (r_state != ST_IDLE);
   assign w_clr_ovr   = swap_req && (r_state == ST_IDLE);
   assign w_to_exp    = (r_to == TW'(TIMEOUT));

   vga_swap_pending u_pend (
      .i_clk     (sys_clk_clk),
      .i_rst_n   (sys_reset_reset_n),
      .i_push    (w_push),
      .i_addr    (w_req_addr),
      .i_pop     (w_start),
      .i_clr_ovr (w_clr_ovr),
      .o_vld     (w_pend_vld),
      .o_vld_nxt (w_pend_vld_nxt),
      .o_addr    (w_pend_addr),
      .o_overrun (swap_overrun)
   );

   always_comb begin
      w_next   = r_state;
      w_to_evt = 1'b0;
      w_start  = 1'b0;
      case (r_state)
         ST_IDLE: if (swap_req || w_pend_vld) begin
            w_next  = ST_WR_BACK;
            w_start = 1'b1;
         end
         ST_WR_BACK: w_next = ST_WR_TRIG;
         ST_WR_TRIG: w_next = ST_GAP;
         ST_GAP: begin
            if (w_to_exp) begin
               w_next   = ST_IDLE;
               w_to_evt = 1'b1;
            end else if (r_cnt == '0) begin
               w_next = ST_RD;
            end
         end
         // An expired timer still lets the issued read drain before giving up.
         ST_RD: w_next = ST_WAIT;
         ST_WAIT: if (r_cnt == '0) begin
            if (!avm_readdata[STATUS_SWAP_BIT]) begin
               w_next = ST_DONE;
            end else if (w_to_exp) begin
               w_next   = ST_IDLE;
               w_to_evt = 1'b1;
            end else begin
               w_next = ST_GAP;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
      if (!sys_reset_reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_to    <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == ST_GAP && r_state != ST_GAP)
            r_cnt <= DW'(POLL_GAP - 1);
         else if (w_next == ST_WAIT && r_state != ST_WAIT)
            r_cnt <= DW'(READ_LATENCY - 1);
         else if (r_cnt != '0)
            r_cnt <= r_cnt - DW'(1);
         if (r_state == ST_WR_TRIG)
            r_to <= '0;
         else if ((r_state == ST_GAP || r_state == ST_RD || r_state == ST_WAIT) && !w_to_exp)
            r_to <= r_to + TW'(1);
      end
   end

   // Bus and status outputs are registered from the next state.
   always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
      if (!sys_reset_reset_n) begin
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_addr  <= REG_FRONT;
         r_be    <= 4'h0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_fc    <= '0;
         r_tout  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_wr    <= (w_next == ST_WR_BACK) || (w_next == ST_WR_TRIG);
         r_rd    <= (w_next == ST_RD);
         r_addr  <= (w_next == ST_WR_BACK) ? REG_BACK :
                    (w_next == ST_RD)      ? REG_STATUS : REG_FRONT;
         r_be    <= (w_next == ST_WR_BACK || w_next == ST_WR_TRIG || w_next == ST_RD) ? 4'hF : 4'h0;
         r_wdata <= (w_next == ST_WR_BACK) ? w_sel_addr : '0;
         r_done  <= (w_next == ST_DONE);
         if (w_next == ST_DONE)
            r_fc <= r_fc + CNT_W'(1);
         if (w_to_evt)
            r_tout <= 1'b1;
         else if (swap_req)
            r_tout <= 1'b0;
         r_busy  <= (w_next != ST_IDLE) || w_pend_vld_nxt;
      end
   end

   assign swap_busy      = r_busy;
   assign swap_done      = r_done;
   assign swap_timeout   = r_tout;
   assign frame_count    = r_fc;
   assign avm_address    = r_addr;
   assign avm_read       = r_rd;
   assign avm_write      = r_wr;
   assign avm_byteenable = r_be;
   assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_vga_frame_swap_ctrl.sv
// Bench for vga_frame_swap_ctrl: a DMA-slave model with delayed status reads,
// table vectors, hand-written corner sequences and randomized flip bursts.
module tb_vga_frame_swap_ctrl;

   localparam int RL = 3;
   localparam int PG = 4;
   localparam int TO = 500;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   rdata = 32'hFFFF_FFFF;
   logic          busy, done, tout, ovr, ard, awr;
   logic [CW-1:0] fc;
   logic [1:0]    aa;
   logic [3:0]    be;
   logic [31:0]   wd;

   always #5 clk = ~clk;

   vga_frame_swap_ctrl #(.READ_LATENCY(RL), .POLL_GAP(PG), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .sys_clk_clk       (clk),
      .sys_reset_reset_n (rst_n),
      .swap_req          (req),
      .swap_addr         (addr),
      .swap_busy         (busy),
      .swap_done         (done),
      .swap_timeout      (tout),
      .swap_overrun      (ovr),
      .frame_count       (fc),
      .avm_address       (aa),
      .avm_read          (ard),
      .avm_write         (awr),
      .avm_byteenable    (be),
      .avm_writedata     (wd),
      .avm_readdata      (rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct { int cyc; logic [1:0] a; logic [31:0] d; } wr_t;
   wr_t           wq[$];
   wr_t           ewq[$];
   logic [CW-1:0] fc_log[$];
   int            sched_cyc[$];
   logic          sched_val[$];
   int rd_cnt = 0, done_cnt = 0, strobe_cnt = 0, cyc = 0, req_cyc = 0;
   int polls_left = 0, cfg_polls = 0;

   // Slave model: status reads answer exactly RL cycles later; all-ones garbage otherwise.
   always @(negedge clk) begin
      if (!rst_n) begin
         sched_cyc.delete();
         sched_val.delete();
         rdata = 32'hFFFF_FFFF;
      end else begin
         cyc++;
         rdata = 32'hFFFF_FFFF;
         if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
            rdata = {31'h0, sched_val[0]};
            void'(sched_cyc.pop_front());
            void'(sched_val.pop_front());
         end
         if (req) req_cyc = cyc;
         if (awr || ard) strobe_cnt++;
         if (awr) begin
            wq.push_back('{cyc, aa, wd});
            chk("wr_be", be, 4'hF);
            chk("wr_excl", ard, 0);
            if (aa == 2'd0) polls_left = cfg_polls;
         end
         if (ard) begin
            chk("rd_addr", aa, 3);
            chk("rd_be", be, 4'hF);
            rd_cnt++;
            sched_cyc.push_back(cyc + RL);
            sched_val.push_back(polls_left > 0);
            if (polls_left > 0) polls_left--;
         end
         if (done) begin
            done_cnt++;
            fc_log.push_back(fc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] a);
      @(posedge clk); #1;
      req = 1'b1; addr = a;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      chk({nm, "_idle"}, busy, 0);
   endtask

   task automatic clr();
      wq.delete(); fc_log.delete();
      rd_cnt = 0; done_cnt = 0; strobe_cnt = 0;
   endtask

   task automatic cmp_writes(input string nm);
      chk({nm, "_nwr"}, wq.size(), ewq.size());
      for (int k = 0; k < wq.size() && k < ewq.size(); k++) begin
         chk({nm, "_wa"}, wq[k].a, ewq[k].a);
         chk({nm, "_wd"}, wq[k].d, ewq[k].d);
      end
   endtask

   typedef struct {
      logic [31:0] a0, ax, a1;
      int nx, polls;
      logic [31:0] w0, w2;
      int nwr, rds, dn, fcx;
      logic ov;
   } vec_t;
   vec_t tbl[3];

   initial begin
      int first, el, n, nx, p, flips, fc_m;
      logic [31:0] a0, last;
      int exp_wrap[5];
      exp_wrap = '{1, 2, 3, 0, 1};

      tbl[0] = '{32'h0800_0003, 32'h0, 32'h0, 0, 3, 32'h0800_0000, 32'h0, 2, 4, 1, 1, 1'b0};
      tbl[1] = '{32'h1000_0000, 32'h2000_0001, 32'h3000_0002, 2, 2, 32'h1000_0000, 32'h3000_0000, 4, 6, 2, 3, 1'b1};
      tbl[2] = '{32'hFFFF_FFFF, 32'h0, 32'h0000_0005, 1, 0, 32'hFFFF_FFFC, 32'h0000_0004, 4, 2, 2, 1, 1'b0};

      // Reset values
      #2;
      chk("rst_outs", {busy, done, tout, ovr, fc, aa, ard, awr, be}, 0);
      chk("rst_wd", wd, 0);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("post_rst_outs", {busy, done, tout, ovr, fc, aa, ard, awr, be}, 0);

      // Table vectors: single flip, overrun burst, single pending
      for (int i = 0; i < 3; i++) begin
         clr();
         cfg_polls = tbl[i].polls;
         pulse(tbl[i].a0);
         first = req_cyc;
         for (int j = 0; j < tbl[i].nx; j++)
            pulse((j == tbl[i].nx - 1) ? tbl[i].a1 : tbl[i].ax);
         wait_idle(700, "tbl");
         ewq.delete();
         ewq.push_back('{0, 2'd1, tbl[i].w0});
         ewq.push_back('{0, 2'd0, 32'h0});
         if (tbl[i].nwr == 4) begin
            ewq.push_back('{0, 2'd1, tbl[i].w2});
            ewq.push_back('{0, 2'd0, 32'h0});
         end
         cmp_writes("tbl");
         if (wq.size() >= 2) begin
            chk("lat_back", wq[0].cyc - first, 1);
            chk("lat_trig", wq[1].cyc - first, 2);
         end
         chk("tbl_reads", rd_cnt, tbl[i].rds);
         chk("tbl_done", done_cnt, tbl[i].dn);
         chk("tbl_fc", fc, tbl[i].fcx);
         chk("tbl_ovr", ovr, tbl[i].ov);
         chk("tbl_tout", tout, 0);
      end

      // Timeout with status stuck pending
      clr();
      cfg_polls = 1000000;
      pulse(32'h0000_1000);
      n = 0;
      while (!tout && n < 700) begin
         tick(1);
         n++;
      end
      chk("to_flag", tout, 1);
      if (wq.size() >= 2) begin
         el = cyc + 1 - wq[1].cyc;
         chk("to_window", (el >= TO) && (el <= TO + PG + RL + 2), 1);
      end
      chk("to_no_done", done_cnt, 0);
      chk("to_fc", fc, 1);
      chk("to_idle", busy, 0);
      cfg_polls = 0;
      pulse(32'h0000_2000);
      chk("to_clear", tout, 0);
      wait_idle(700, "to");
      chk("to_next_done", done_cnt, 1);
      chk("to_next_fc", fc, 2);

      // Reset while waiting on read latency
      clr();
      cfg_polls = 1000000;
      pulse(32'h0000_4000);
      n = 0;
      while (!ard && n < 50) begin
         tick(1);
         n++;
      end
      chk("mid_rd_seen", ard, 1);
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {busy, done, tout, ovr, fc, aa, ard, awr, be}, 0);
      chk("mid_rst_wd", wd, 0);
      tick(2);
      rst_n = 1'b1;
      n = strobe_cnt;
      tick(40);
      chk("mid_no_strobe", strobe_cnt - n, 0);
      chk("mid_busy", busy, 0);
      cfg_polls = 1;
      pulse(32'h0000_5000);
      wait_idle(700, "mid");
      chk("mid_done", done_cnt, 1);
      chk("mid_fc", fc, 1);

      // Frame counter wrap
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      clr();
      for (int k = 0; k < 5; k++) begin
         cfg_polls = $urandom_range(0, 2);
         pulse($urandom);
         wait_idle(700, "wrap");
      end
      chk("wrap_n", fc_log.size(), 5);
      for (int k = 0; k < fc_log.size() && k < 5; k++)
         chk("wrap_fc", fc_log[k], exp_wrap[k]);

      // Randomized bursts against the request-level model
      fc_m = 1;
      for (int it = 0; it < 12; it++) begin
         clr();
         nx = $urandom_range(0, 3);
         p  = $urandom_range(0, 3);
         cfg_polls = p;
         a0 = $urandom;
         last = a0;
         pulse(a0);
         for (int j = 0; j < nx; j++) begin
            last = $urandom;
            pulse(last);
         end
         wait_idle(900, "rnd");
         flips = (nx > 0) ? 2 : 1;
         ewq.delete();
         ewq.push_back('{0, 2'd1, a0 & 32'hFFFF_FFFC});
         ewq.push_back('{0, 2'd0, 32'h0});
         if (nx > 0) begin
            ewq.push_back('{0, 2'd1, last & 32'hFFFF_FFFC});
            ewq.push_back('{0, 2'd0, 32'h0});
         end
         cmp_writes("rnd");
         fc_m = (fc_m + flips) % (1 << CW);
         chk("rnd_reads", rd_cnt, flips * (p + 1));
         chk("rnd_done", done_cnt, flips);
         chk("rnd_fc", fc, fc_m);
         chk("rnd_ovr", ovr, nx >= 2);
         tick($urandom_range(0, 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
